// File: rtl/sram_fetch_pkg.sv
// sram_fetch_pkg
//   Shared types and constants for the SRAM fetch controller.
//   - fetch_state_t : controller FSM states
//   - *_DFLT        : default region sizes (words) used as parameter defaults
//   - TOTAL_WORDS   : words fetched per run with the default region sizes
//   - IDX_W         : width of the per-region word index presented downstream
package sram_fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_W,
    FETCH_I,
    DRAIN,
    DONE
  } fetch_state_t;

  localparam int WEIGHT_WORDS_DFLT = 512;
  localparam int IMAGE_WORDS_DFLT  = 32;
  localparam int TOTAL_WORDS       = WEIGHT_WORDS_DFLT + IMAGE_WORDS_DFLT;
  localparam int IDX_W             = 10;

endpackage

// File: rtl/sram_fetch_ctrl_fifo.sv
// sync_fifo
//   Small synchronous FIFO with show-ahead head (dout is the oldest entry,
//   valid whenever empty=0). Push and pop may coincide at any fill level; a
//   push into a full FIFO succeeds only when a pop frees the slot in the same
//   cycle. There is no fall-through: a push into an empty FIFO is visible the
//   next cycle.
// Ports:
//   clk, rst     clock, asynchronous active-high reset (flushes pointers)
//   push, din    write strobe and data
//   pop          remove the head entry (ignored while empty)
//   dout         head entry
//   full, empty  status flags
//   count        number of stored entries
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign count   = count_reg;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr_reg];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage needs no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

endmodule

// File: rtl/sram_fetch_ctrl.sv
// sram_fetch_ctrl
//   Streams the weight region and then the image region out of a fixed
//   latency SRAM into a small output FIFO, and presents the words downstream
//   on valid/ready, tagged with region and per-region word index.
//   Reads are issued only while (reads in flight + FIFO occupancy) stays
//   below FIFO_DEPTH, so every returning word always has a FIFO slot.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   start            begin a fetch (only honoured in IDLE)
//   sram_addr        SRAM word address
//   sram_rd_en       SRAM read strobe
//   sram_rdata       SRAM data, valid RD_LAT cycles after the strobe edge
//   out_data         word to the buffer stage
//   out_valid        out_data valid
//   out_ready        downstream accept
//   out_is_image     0 = weight word, 1 = image word
//   out_index        word index within the current region
//   busy             controller not idle
//   done             one-cycle completion pulse
module sram_fetch_ctrl
  import sram_fetch_pkg::*;
#(
  parameter int                ADDR_W       = 16,
  parameter int                DATA_W       = 32,
  parameter logic [ADDR_W-1:0] WEIGHT_BASE  = 16'h0000,
  parameter logic [ADDR_W-1:0] IMAGE_BASE   = 16'h0200,
  parameter int                WEIGHT_WORDS = WEIGHT_WORDS_DFLT,
  parameter int                IMAGE_WORDS  = IMAGE_WORDS_DFLT,
  parameter int                RD_LAT       = 2,
  parameter int                FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_rd_en,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_is_image,
  output logic [IDX_W-1:0]  out_index,
  output logic              busy,
  output logic              done
);

  localparam int TOT_WORDS = WEIGHT_WORDS + IMAGE_WORDS;
  localparam int CNT_W     = $clog2(TOT_WORDS + 1);
  localparam int FCNT_W    = $clog2(FIFO_DEPTH + 1);

  fetch_state_t      state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              rd_en_reg;
  logic [CNT_W-1:0]  issue_cnt_reg;
  logic [CNT_W-1:0]  acc_cnt_reg;
  logic [RD_LAT-1:0] pipe_reg;

  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_empty;
  logic              fifo_full_unused;
  logic [FCNT_W-1:0] fifo_count;
  logic              fifo_push;
  logic              pop;
  logic              last_weight_issue;
  logic              last_issue;
  logic [CNT_W-1:0]  idx_full;
  int                inflight_cnt;
  int                pending_now;
  int                pending_next;

  // Read-return tracker: one bit per SRAM pipeline stage. The oldest stage
  // marks the cycle its data is on sram_rdata. Reset clears it, so data
  // still coming back from before a reset is never pushed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_reg <= '0;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) pipe_reg[i] <= pipe_reg[i-1];
      pipe_reg[0] <= rd_en_reg;
    end
  end

  assign fifo_push = pipe_reg[RD_LAT-1];
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (FCNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (sram_rdata),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full_unused),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Credits in use now and after this edge. A return moves a word from the
  // tracker into the FIFO and leaves the total unchanged, so only the issue
  // at this edge and the pop at this edge matter.
  always_comb begin
    inflight_cnt = 0;
    for (int i = 0; i < RD_LAT; i++) inflight_cnt = inflight_cnt + (pipe_reg[i] ? 1 : 0);
    pending_now  = inflight_cnt + int'(fifo_count);
    pending_next = pending_now + (rd_en_reg ? 1 : 0) - (pop ? 1 : 0);
  end

  assign last_weight_issue = rd_en_reg && (issue_cnt_reg == CNT_W'(WEIGHT_WORDS - 1));
  assign last_issue        = rd_en_reg && (issue_cnt_reg == CNT_W'(TOT_WORDS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      rd_en_reg     <= 1'b0;
      issue_cnt_reg <= '0;
      acc_cnt_reg   <= '0;
    end else begin
      if (pop) acc_cnt_reg <= acc_cnt_reg + 1'b1;
      case (state_reg)
        IDLE: begin
          rd_en_reg <= 1'b0;
          if (start) begin
            state_reg     <= FETCH_W;
            addr_reg      <= WEIGHT_BASE;
            rd_en_reg     <= 1'b1;
            issue_cnt_reg <= '0;
            acc_cnt_reg   <= '0;
          end
        end
        FETCH_W, FETCH_I: begin
          if (rd_en_reg) begin
            addr_reg      <= last_weight_issue ? IMAGE_BASE : addr_reg + 1'b1;
            issue_cnt_reg <= issue_cnt_reg + 1'b1;
          end
          rd_en_reg <= !last_issue && (pending_next < FIFO_DEPTH);
          if (last_issue)             state_reg <= DRAIN;
          else if (last_weight_issue) state_reg <= FETCH_I;
        end
        DRAIN: begin
          rd_en_reg <= 1'b0;
          if (pending_now == 0 && acc_cnt_reg == CNT_W'(TOT_WORDS)) state_reg <= DONE;
        end
        DONE: begin
          rd_en_reg     <= 1'b0;
          state_reg     <= IDLE;
          issue_cnt_reg <= '0;
          acc_cnt_reg   <= '0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Tags follow the accept counter; the FIFO only stores data.
  assign idx_full     = (acc_cnt_reg >= CNT_W'(WEIGHT_WORDS)) ?
                        acc_cnt_reg - CNT_W'(WEIGHT_WORDS) : acc_cnt_reg;
  assign out_is_image = (acc_cnt_reg >= CNT_W'(WEIGHT_WORDS));
  assign out_index    = IDX_W'(idx_full);
  assign out_data     = out_valid ? fifo_dout : '0;
  assign sram_addr    = addr_reg;
  assign sram_rd_en   = rd_en_reg;
  assign busy         = (state_reg != IDLE);
  assign done         = (state_reg == DONE);

endmodule

// File: tb/tb_sram_fetch_ctrl.sv
// tb_sram_fetch_ctrl
//   Two controller instances share clock and reset:
//     channel 0: RD_LAT=2, FIFO_DEPTH=4 (default configuration)
//     channel 1: RD_LAT=1, FIFO_DEPTH=2 with random out_ready
//   Each channel has its own SRAM model and a monitor that compares every
//   accepted word and every issued address against the expected stream
//   (weights 0x0000..0x01FF, then image 0x0200..0x021F).
module tb_sram_fetch_ctrl;

  localparam int W_WORDS = 512;
  localparam int I_WORDS = 32;
  localparam int TOTAL   = W_WORDS + I_WORDS;

  logic        clk;
  logic        rst;
  int          cyc = 0;
  logic [31:0] salt;
  int          n_checks = 0;
  int          n_errors = 0;

  logic start_s [2];
  logic ready_s [2];
  logic clr_s   [2];
  logic done_w  [2];
  logic busy_w  [2];
  logic rd_w    [2];
  logic valid_w [2];
  int   iss_w   [2];
  int   acc_w   [2];
  int   dcnt_w  [2];
  int   fv_w    [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] sram_word(input logic [15:0] a);
    logic [15:0] hi;
    logic [15:0] lo;
    hi = (a * 16'd40503) ^ salt[31:16];
    lo = a ^ salt[15:0];
    return {hi, lo};
  endfunction

  // Expected address of the k-th word of a run.
  function automatic logic [15:0] exp_addr(input int k);
    if (k < W_WORDS) return 16'(k);
    return 16'(32'h200 + k - W_WORDS);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    localparam int LAT = (gi == 0) ? 2 : 1;
    localparam int DEP = (gi == 0) ? 4 : 2;

    logic [15:0] addr;
    logic        rd_en;
    logic [31:0] rdata;
    logic [31:0] odata;
    logic        ovalid;
    logic        oimg;
    logic [9:0]  oidx;
    logic        obusy;
    logic        odone;
    logic [31:0] sram_pipe [LAT];

    int          issued = 0;
    int          accepted = 0;
    int          done_cnt = 0;
    int          first_valid = -1;
    logic        stalled = 1'b0;
    logic        prev_done = 1'b0;
    logic [31:0] held_data = '0;
    logic [9:0]  held_idx = '0;

    sram_fetch_ctrl #(
      .RD_LAT     (LAT),
      .FIFO_DEPTH (DEP)
    ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start_s[gi]),
      .sram_addr    (addr),
      .sram_rd_en   (rd_en),
      .sram_rdata   (rdata),
      .out_data     (odata),
      .out_valid    (ovalid),
      .out_ready    (ready_s[gi]),
      .out_is_image (oimg),
      .out_index    (oidx),
      .busy         (obusy),
      .done         (odone)
    );

    // SRAM: data for the address sampled at an edge appears LAT cycles later;
    // outside valid slots the bus carries junk.
    always @(posedge clk) begin
      sram_pipe[0] <= rd_en ? sram_word(addr) : $urandom();
      for (int i = 1; i < LAT; i++) sram_pipe[i] <= sram_pipe[i-1];
    end
    assign rdata = sram_pipe[LAT-1];

    assign done_w[gi]  = odone;
    assign busy_w[gi]  = obusy;
    assign rd_w[gi]    = rd_en;
    assign valid_w[gi] = ovalid;
    assign iss_w[gi]   = issued;
    assign acc_w[gi]   = accepted;
    assign dcnt_w[gi]  = done_cnt;
    assign fv_w[gi]    = first_valid;

    always @(negedge clk) begin
      if (rst || clr_s[gi]) begin
        issued      <= 0;
        accepted    <= 0;
        done_cnt    <= 0;
        first_valid <= -1;
        stalled     <= 1'b0;
        prev_done   <= 1'b0;
      end else begin
        if (ovalid && first_valid < 0) first_valid <= cyc;
        if (stalled) begin
          check_eq($sformatf("ch%0d_hold_valid", gi), 32'(ovalid), 32'd1);
          check_eq($sformatf("ch%0d_hold_data", gi), odata, held_data);
          check_eq($sformatf("ch%0d_hold_index", gi), 32'(oidx), 32'(held_idx));
        end
        stalled   <= ovalid && !ready_s[gi];
        held_data <= odata;
        held_idx  <= oidx;
        if (ovalid && ready_s[gi]) begin
          if (accepted >= TOTAL) begin
            check_eq($sformatf("ch%0d_extra_word", gi), 32'(accepted), 32'(TOTAL - 1));
          end else begin
            check_eq($sformatf("ch%0d_data_w%0d", gi, accepted), odata, sram_word(exp_addr(accepted)));
            check_eq($sformatf("ch%0d_is_image_w%0d", gi, accepted), 32'(oimg), 32'(accepted >= W_WORDS));
            check_eq($sformatf("ch%0d_index_w%0d", gi, accepted), 32'(oidx),
                     32'((accepted >= W_WORDS) ? accepted - W_WORDS : accepted));
            $display("ch%0d word %0d img=%0d idx=%0d data=%08h", gi, accepted, oimg, oidx, odata);
          end
        end
        if (rd_en) begin
          if (issued >= TOTAL)
            check_eq($sformatf("ch%0d_extra_issue", gi), 32'(issued), 32'(TOTAL - 1));
          else
            check_eq($sformatf("ch%0d_addr_r%0d", gi, issued), 32'(addr), 32'(exp_addr(issued)));
        end
        // Reads outstanding after the coming edge must fit in the FIFO.
        check_eq($sformatf("ch%0d_no_overflow", gi),
                 32'((issued + (rd_en ? 1 : 0)) - (accepted + ((ovalid && ready_s[gi]) ? 1 : 0)) <= DEP),
                 32'd1);
        if (ovalid && ready_s[gi]) accepted <= accepted + 1;
        if (rd_en) issued <= issued + 1;
        if (prev_done) check_eq($sformatf("ch%0d_busy_after_done", gi), 32'(obusy), 32'd0);
        prev_done <= odone;
        if (odone) begin
          done_cnt <= done_cnt + 1;
          check_eq($sformatf("ch%0d_done_complete", gi), 32'(accepted), 32'(TOTAL));
        end
      end
    end
  end

  task automatic start_fetch(input int ch, output int k0);
    @(posedge clk); #1; clr_s[ch] = 1'b1;
    @(posedge clk); #1; clr_s[ch] = 1'b0; start_s[ch] = 1'b1;
    @(posedge clk); #1; start_s[ch] = 1'b0; k0 = cyc;
  endtask

  task automatic wait_done(input int ch, input int budget);
    int n;
    n = 0;
    while (!done_w[ch] && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq($sformatf("ch%0d_done_seen", ch), 32'(done_w[ch]), 32'd1);
  endtask

  task automatic wait_count(input int ch, input bit use_iss, input int target, input int budget);
    int n;
    n = 0;
    while (((use_iss ? iss_w[ch] : acc_w[ch]) < target) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq($sformatf("ch%0d_reach_%0d", ch, target),
             32'((use_iss ? iss_w[ch] : acc_w[ch]) >= target), 32'd1);
  endtask

  task automatic finish_checks(input int ch);
    check_eq($sformatf("ch%0d_words_accepted", ch), 32'(acc_w[ch]), 32'(TOTAL));
    check_eq($sformatf("ch%0d_reads_issued", ch), 32'(iss_w[ch]), 32'(TOTAL));
    check_eq($sformatf("ch%0d_done_pulses", ch), 32'(dcnt_w[ch]), 32'd1);
    check_eq($sformatf("ch%0d_idle_after", ch), 32'(busy_w[ch]), 32'd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_valid"}, 32'(g_ch[0].ovalid), 32'd0);
    check_eq({tag, "_rd_en"}, 32'(g_ch[0].rd_en), 32'd0);
    check_eq({tag, "_busy"}, 32'(g_ch[0].obusy), 32'd0);
    check_eq({tag, "_done"}, 32'(g_ch[0].odone), 32'd0);
    check_eq({tag, "_data"}, g_ch[0].odata, 32'd0);
    check_eq({tag, "_index"}, 32'(g_ch[0].oidx), 32'd0);
    check_eq({tag, "_is_image"}, 32'(g_ch[0].oimg), 32'd0);
    check_eq({tag, "_addr"}, 32'(g_ch[0].addr), 32'd0);
  endtask

  initial begin
    int k0;
    int iss_before;
    salt = $urandom();
    rst  = 1'b1;
    for (int c = 0; c < 2; c++) begin
      start_s[c] = 1'b0;
      ready_s[c] = 1'b1;
      clr_s[c]   = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst = 1'b0;

    // Full fetch, always ready.
    start_fetch(0, k0);
    wait_done(0, 3000);
    check_eq("ch0_first_valid_latency", 32'(fv_w[0] - k0), 32'd3);
    repeat (3) begin @(posedge clk); #1; end
    finish_checks(0);

    // Backpressure mid-weights, then start pulses in FETCH_I and in DONE.
    start_fetch(0, k0);
    wait_count(0, 1'b0, 200, 1000);
    ready_s[0] = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    check_eq("ch0_bp_outstanding", 32'(iss_w[0] - acc_w[0]), 32'd4);
    check_eq("ch0_bp_rd_en_off", 32'(rd_w[0]), 32'd0);
    iss_before = iss_w[0];
    ready_s[0] = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    check_eq("ch0_bp_issue_resumed", 32'(iss_w[0] > iss_before), 32'd1);
    wait_count(0, 1'b1, 520, 1000);
    start_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    wait_done(0, 1000);
    start_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    finish_checks(0);

    // Reset in the middle of a run, then a clean refetch.
    start_fetch(0, k0);
    wait_count(0, 1'b0, 100, 1000);
    rst = 1'b1;
    #1;
    check_zero_outputs("midrun_reset");
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check_eq("post_reset_valid", 32'(valid_w[0]), 32'd0);
      check_eq("post_reset_rd_en", 32'(rd_w[0]), 32'd0);
      @(posedge clk); #1;
    end
    start_fetch(0, k0);
    wait_done(0, 3000);
    check_eq("ch0_refetch_first_valid_latency", 32'(fv_w[0] - k0), 32'd3);
    repeat (3) begin @(posedge clk); #1; end
    finish_checks(0);

    // Short latency, two-entry FIFO, random downstream ready.
    start_fetch(1, k0);
    for (int n = 0; n < 20000; n++) begin
      @(posedge clk); #1;
      ready_s[1] = 1'($urandom_range(0, 1));
      if (done_w[1]) break;
    end
    check_eq("ch1_done_seen", 32'(done_w[1]), 32'd1);
    check_eq("ch1_first_valid_latency", 32'(fv_w[1] - k0), 32'd2);
    ready_s[1] = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    finish_checks(1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_fetch_ctrl.md
Name: sram_fetch_ctrl

Overview:
- Upstream feeder for the SRAM buffer stage.
- On a start pulse, streams the weight region (1024 x 16-bit, packed into 512 words) and then the image region (64 x 16-bit, packed into 32 words) out of a fixed-latency 32-bit SRAM.
- Presents words downstream on a valid/ready interface, tagged with region and word index, and pulses done after the last word is accepted.
- Credit-based issue into a small FIFO absorbs downstream backpressure without losing in-flight reads.

Parameters:
- ADDR_W, 16, SRAM word address width
- DATA_W, 32, SRAM data width (two 16-bit elements per word, element 2n in bits [15:0])
- WEIGHT_BASE, 16'h0000, first weight word address
- IMAGE_BASE, 16'h0200, first image word address
- WEIGHT_WORDS, 512, weight words to fetch
- IMAGE_WORDS, 32, image words to fetch
- RD_LAT, 2, SRAM read latency in cycles (legal 1..4)
- FIFO_DEPTH, 4, output FIFO entries; must be >= 2

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a fetch; sampled only in IDLE
- sram_addr  out  ADDR_W  SRAM read address
- sram_rd_en  out  1  SRAM read strobe
- sram_rdata  in  DATA_W  SRAM read data, valid RD_LAT cycles after the rd_en edge
- out_data  out  DATA_W  word to the buffer stage
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts the word when out_valid and out_ready are both high at an edge
- out_is_image  out  1  0 = weight word, 1 = image word
- out_index  out  10  word index within the current region
- busy  out  1  high whenever state != IDLE
- done  out  1  single-cycle pulse, fetch complete

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; FIFO flushed; in-flight tracker cleared; issue and accept counters cleared. Data returning after reset is discarded.
- Timing: start sampled high at edge k moves to FETCH_W. sram_rd_en is high with addr=WEIGHT_BASE after edge k. The SRAM samples it at edge k+1; data is written to the FIFO at edge k+1+RD_LAT; out_valid rises after that edge (edge 3 for RD_LAT=2).
- Issue rule: sram_rd_en=1 only if (inflight + fifo_count) < FIFO_DEPTH and words remain. This guarantees the FIFO never overflows.
- inflight is a RD_LAT-deep valid shift register and is reduced on return.
- Address increments by 1 per issued read.
- FSM states and transitions:
  - IDLE -> FETCH_W on start.
  - FETCH_W -> FETCH_I on the same edge the last weight read (WEIGHT_BASE+WEIGHT_WORDS-1) issues. The next issue uses IMAGE_BASE.
  - FETCH_I -> DRAIN when the last image read issues.
  - DRAIN -> DONE when inflight==0, the FIFO is empty, and all WEIGHT_WORDS+IMAGE_WORDS words have been accepted.
  - DONE -> IDLE unconditionally after one cycle. done=1 only in DONE.
- Accept counter increments per accepted word.
  - out_is_image = (count >= WEIGHT_WORDS).
  - out_index = count, or count - WEIGHT_WORDS for image words.
- out_data / out_valid / tags are held stable while out_valid=1 and out_ready=0.
- FIFO push and pop in the same cycle are allowed at any fill level, including full and empty. Push on empty with no pop gives out_valid the next cycle; there is no fall-through.
- start while busy (including in DONE) is ignored, with no restart and no queueing.
- out_ready with out_valid=0 has no effect.

Decomposition:
- Package sram_fetch_pkg holds:
  - state enum fetch_state_t {IDLE, FETCH_W, FETCH_I, DRAIN, DONE}
  - localparams: TOTAL_WORDS = WEIGHT_WORDS+IMAGE_WORDS, IDX_W=10
- Sub-module sync_fifo (parameterised width/depth, push/pop/full/empty/count, async active-high reset) holds the output queue. Its width is DATA_W. Tags are derived from the accept counter and are not stored.

Test Plan:
- Full fetch, out_ready=1, RD_LAT=2: start at edge 0. Expect:
  - first out_valid after edge 3;
  - 544 words accepted, addresses 0x0000..0x01FF then 0x0200..0x021F, data matching the SRAM model;
  - exactly one done pulse;
  - busy low the cycle after done.
- Backpressure: out_ready=0 for 20 cycles mid-weights. Expect:
  - sram_rd_en stops once inflight+fifo_count=4;
  - no word dropped or duplicated;
  - out_data held stable;
  - issue resumes on ready.
- Region boundary: the 512th accepted word has is_image=0, index 511; the next has is_image=1, index 0, address 0x0200 data.
- start pulsed during FETCH_I and during DONE: the address sequence is unchanged, there is no second fetch, and done pulses once.
- rst asserted at word 100 with 2 reads in flight: all outputs 0 immediately; returning data is not emitted; a new start refetches from address 0x0000 with index 0.
- RD_LAT=1, FIFO_DEPTH=2, random out_ready at 50%: all 544 words arrive in order and the FIFO never overflows (assertion).
